// File: rtl/player_mover.sv
// Moves the 4x4 player block on the wall grid. Each move scans the target
// edge one cell per cycle against the map ROM before the position is committed.
module player_mover #(
  parameter int MAP_W   = 40,
  parameter int MAP_H   = 40,
  parameter int PSZ     = 4,
  parameter int START_X = 34,
  parameter int START_Y = 35
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic       move_req,
  input  logic [1:0] dir,
  output logic [5:0] q_x,
  output logic [5:0] q_y,
  input  logic       q_wall,
  output logic       busy,
  output logic       done,
  output logic       blocked,
  output logic [5:0] player_x,
  output logic [5:0] player_y,
  output logic       at_exit
);

  localparam int         IW   = (PSZ > 1) ? $clog2(PSZ) : 1;
  localparam logic [6:0] W7   = 7'(MAP_W);
  localparam logic [6:0] H7   = 7'(MAP_H);
  localparam logic [6:0] P7   = 7'(PSZ);
  localparam logic [IW-1:0] LAST = IW'(PSZ - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} fsm_e;

  fsm_e          fsm_q;
  logic [3:0]    prev_state_q;
  logic [1:0]    dir_q;
  logic [IW-1:0] idx_q;
  logic          wall_q;
  logic [5:0]    qx_q, qy_q, px_q, py_q;
  logic          busy_q, done_q, blocked_q, at_exit_q;

  logic       stage_chg, active, eff_wall, oor;
  logic [6:0] px7, py7, edge_x, edge_y;
  logic [5:0] mv_x, mv_y;

  assign stage_chg = (state != prev_state_q);
  assign active    = (state == 4'd2) || (state == 4'd4) || (state == 4'd6);
  assign eff_wall  = wall_q | q_wall;
  assign px7       = {1'b0, px_q};
  assign py7       = {1'b0, py_q};

  // First cell of the target edge; underflow is tested before subtracting.
  always_comb begin
    edge_x = px7;
    edge_y = py7;
    oor    = 1'b0;
    case (dir)
      2'd0: begin oor = (py_q == 6'd0); edge_y = py7 - 7'd1; end
      2'd1: begin edge_y = py7 + P7;    oor = (edge_y >= H7); end
      2'd2: begin oor = (px_q == 6'd0); edge_x = px7 - 7'd1; end
      default: begin edge_x = px7 + P7; oor = (edge_x >= W7); end
    endcase
  end

  always_comb begin
    mv_x = px_q;
    mv_y = py_q;
    case (dir_q)
      2'd0:    mv_y = py_q - 6'd1;
      2'd1:    mv_y = py_q + 6'd1;
      2'd2:    mv_x = px_q - 6'd1;
      default: mv_x = px_q + 6'd1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= IDLE;
      prev_state_q <= 4'd0;
      dir_q        <= 2'd0;
      idx_q        <= '0;
      wall_q       <= 1'b0;
      qx_q         <= 6'd0;
      qy_q         <= 6'd0;
      px_q         <= 6'(START_X);
      py_q         <= 6'(START_Y);
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      blocked_q    <= 1'b0;
      at_exit_q    <= 1'b0;
    end else begin
      prev_state_q <= state;
      // A stage change wins over everything and silently drops the request.
      if (stage_chg) begin
        fsm_q     <= IDLE;
        px_q      <= 6'(START_X);
        py_q      <= 6'(START_Y);
        busy_q    <= 1'b0;
        done_q    <= 1'b0;
        blocked_q <= 1'b0;
        at_exit_q <= 1'b0;
      end else begin
        case (fsm_q)
          IDLE: begin
            if (move_req && active) begin
              dir_q  <= dir;
              busy_q <= 1'b1;
              if (oor) begin
                fsm_q     <= DONE;
                done_q    <= 1'b1;
                blocked_q <= 1'b1;
              end else begin
                fsm_q  <= SCAN;
                idx_q  <= '0;
                wall_q <= 1'b0;
                qx_q   <= edge_x[5:0];
                qy_q   <= edge_y[5:0];
              end
            end
          end
          SCAN: begin
            wall_q <= eff_wall;
            if (idx_q == LAST) begin
              fsm_q     <= DONE;
              done_q    <= 1'b1;
              blocked_q <= eff_wall;
              if (!eff_wall) begin
                px_q      <= mv_x;
                py_q      <= mv_y;
                at_exit_q <= (mv_x == 6'd0);
              end
            end else begin
              idx_q <= idx_q + 1'b1;
              // Left/right edges run down a column, up/down edges along a row.
              if (dir_q[1]) qy_q <= qy_q + 6'd1;
              else          qx_q <= qx_q + 6'd1;
            end
          end
          DONE: begin
            fsm_q     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            blocked_q <= 1'b0;
          end
          default: fsm_q <= IDLE;
        endcase
      end
    end
  end

  assign q_x      = qx_q;
  assign q_y      = qy_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign blocked  = blocked_q;
  assign player_x = px_q;
  assign player_y = py_q;
  assign at_exit  = at_exit_q;

endmodule

// File: tb/tb_player_mover.sv
// Directed and random moves on a stub wall map, checked against a cell-list
// reference model of the player position.
module tb_player_mover;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] state;
  logic       move_req;
  logic [1:0] dir;
  logic [5:0] q_x, q_y;
  logic       q_wall;
  logic       busy, done, blocked, at_exit;
  logic [5:0] player_x, player_y;

  bit wall [40][40];
  int checks = 0;
  int errors = 0;

  int mx, my, lqx, lqy;
  bit ax;

  always #5 clk = ~clk;

  assign q_wall = (q_x < 6'd40 && q_y < 6'd40) ? wall[q_y][q_x] : 1'b0;

  player_mover dut (
    .clk(clk), .rst_n(rst_n), .state(state), .move_req(move_req), .dir(dir),
    .q_x(q_x), .q_y(q_y), .q_wall(q_wall), .busy(busy), .done(done),
    .blocked(blocked), .player_x(player_x), .player_y(player_y), .at_exit(at_exit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_map();
    for (int y = 0; y < 40; y++)
      for (int x = 0; x < 40; x++) wall[y][x] = 1'b0;
  endtask

  // Issue one move and follow it to completion, checking every cycle.
  task automatic do_move(input int d);
    int cx[4];
    int cy[4];
    bit oor, blk;
    int nx, ny;
    oor = 0;
    for (int i = 0; i < 4; i++) begin
      case (d)
        0: begin cx[i] = mx + i; cy[i] = my - 1; oor = (my == 0);       end
        1: begin cx[i] = mx + i; cy[i] = my + 4; oor = (my + 4 >= 40);  end
        2: begin cx[i] = mx - 1; cy[i] = my + i; oor = (mx == 0);       end
        default: begin cx[i] = mx + 4; cy[i] = my + i; oor = (mx + 4 >= 40); end
      endcase
    end
    blk = oor;
    if (!oor)
      for (int i = 0; i < 4; i++) blk |= wall[cy[i]][cx[i]];
    nx = mx; ny = my;
    if (!blk) begin
      if (d == 0) ny = my - 1;
      if (d == 1) ny = my + 1;
      if (d == 2) nx = mx - 1;
      if (d == 3) nx = mx + 1;
    end

    @(negedge clk);
    move_req = 1'b1;
    dir      = 2'(d);
    step();
    move_req = 1'b0;
    if (oor) begin
      chk("oor_done", done, 1);
      chk("oor_blocked", blocked, 1);
      chk("oor_busy", busy, 1);
      chk("oor_qx_hold", q_x, lqx);
      chk("oor_qy_hold", q_y, lqy);
      chk("oor_px", player_x, mx);
      chk("oor_py", player_y, my);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (i > 0) step();
        chk("scan_qx", q_x, cx[i]);
        chk("scan_qy", q_y, cy[i]);
        chk("scan_busy", busy, 1);
        chk("scan_done", done, 0);
      end
      step();
      if (!blk) ax = (nx == 0);
      chk("mv_done", done, 1);
      chk("mv_blocked", blocked, blk);
      chk("mv_px", player_x, nx);
      chk("mv_py", player_y, ny);
      chk("mv_at_exit", at_exit, ax);
      lqx = cx[3];
      lqy = cy[3];
    end
    step();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    mx = nx;
    my = ny;
  endtask

  task automatic set_state(input logic [3:0] s);
    @(negedge clk);
    state = s;
    step();
    mx = 34; my = 35; ax = 0;
    chk("reload_px", player_x, 34);
    chk("reload_py", player_y, 35);
    chk("reload_at_exit", at_exit, 0);
    chk("reload_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    clear_map();
    rst_n = 1'b0; state = 4'd0; move_req = 1'b0; dir = 2'd0;
    mx = 34; my = 35; lqx = 0; lqy = 0; ax = 0;
    #12;
    chk("rst_px", player_x, 34);
    chk("rst_py", player_y, 35);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_blocked", blocked, 0);
    chk("rst_qx", q_x, 0);
    chk("rst_qy", q_y, 0);
    chk("rst_at_exit", at_exit, 0);
    @(negedge clk);
    rst_n = 1'b1;
    state = 4'd2;
    repeat (2) step();
    chk("entry_px", player_x, 34);
    chk("entry_py", player_y, 35);
    chk("entry_busy", busy, 0);

    // Left on an empty map, then left into a wall at (33,37).
    do_move(2);
    set_state(4'd4);
    set_state(4'd2);
    wall[37][33] = 1'b1;
    do_move(2);
    chk("wall_px_kept", player_x, 34);
    wall[37][33] = 1'b0;

    // Right edge out of range from x=36.
    do_move(3);
    do_move(3);
    do_move(3);
    chk("oor_at_36", player_x, 36);

    // Reset during a scan: async return, no done afterwards.
    @(negedge clk);
    move_req = 1'b1; dir = 2'd0;
    step();
    move_req = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    mx = 34; my = 35; lqx = 0; lqy = 0; ax = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_px", player_x, 34);
    chk("midrst_py", player_y, 35);
    chk("midrst_qx", q_x, 0);
    chk("midrst_qy", q_y, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin step(); if (done) ndone++; end
    chk("midrst_no_done", ndone, 0);

    // A second request while busy is ignored.
    ndone = 0;
    @(negedge clk);
    move_req = 1'b1; dir = 2'd2;
    step(); if (done) ndone++;
    @(negedge clk); move_req = 1'b0;
    step(); if (done) ndone++;
    @(negedge clk); move_req = 1'b1; dir = 2'd3;
    step(); if (done) ndone++;
    @(negedge clk); move_req = 1'b0;
    repeat (9) begin step(); if (done) ndone++; end
    chk("busy_one_done", ndone, 1);
    chk("busy_px", player_x, 33);
    mx = 33;

    // Random walls and directions.
    for (int y = 0; y < 40; y++)
      for (int x = 0; x < 40; x++) wall[y][x] = ($urandom_range(11) == 0);
    for (int n = 0; n < 60; n++) do_move(int'($urandom_range(3)));

    // Walk to (1,18) on a clear map, step onto the exit column, then leave the stage.
    clear_map();
    while (mx > 1)  do_move(2);
    while (mx < 1)  do_move(3);
    while (my > 18) do_move(0);
    while (my < 18) do_move(1);
    do_move(2);
    chk("exit_px", player_x, 0);
    chk("exit_flag", at_exit, 1);
    set_state(4'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
